// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: scan states and active-low segment codes {g,f,e,d,c,b,a} shared by the display scan controller
package seg_scan_pkg;
  typedef enum logic {SHOW, BLANK} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: digit-register write port between counter logic (master) and the scan controller (slave)
interface seg_scan_if #(parameter int AW = 2) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/hex7_decode.sv
// hex7_decode: combinational 4-bit hex to active-low 7-segment decoder
module hex7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode display scanner with blanking gap between digits.
// Define SEG_LEADING_ZERO_BLANK_EN to suppress leading zeros on digits above digit 0.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int AW           = 2,
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                rst,
  seg_scan_if.slave           wr,
  input  logic [N_DIGITS-1:0] digit_en,
  output logic [N_DIGITS-1:0] oAn,
  output logic [6:0]          oSeg,
  output logic                frame_done
);
  localparam int PW = $clog2(N_DIGITS);
  localparam int CW = $clog2(SCAN_DIV > BLANK_CYCLES ? SCAN_DIV : BLANK_CYCLES);
  localparam logic [AW:0] N_L = (AW+1)'(N_DIGITS);
  state_t state, state_n;
  logic [CW-1:0] presc, presc_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [3:0] digit [N_DIGITS];
  logic [6:0] dec;
  logic [N_DIGITS-1:0] an_n;
  logic wrap, lz;
  always_comb begin
    state_n = state;
    presc_n = presc + 1'b1;
    ptr_n   = ptr;
    wrap    = 1'b0;
    if (state == SHOW && presc == CW'(SCAN_DIV-1)) begin
      presc_n = '0;
      state_n = BLANK;
    end else if (state == BLANK && presc == CW'(BLANK_CYCLES-1)) begin
      presc_n = '0;
      state_n = SHOW;
      wrap    = ptr == PW'(N_DIGITS-1);
      ptr_n   = wrap ? '0 : ptr + 1'b1;
    end
  end
  hex7_decode u_dec (.hex(digit[ptr]), .seg(dec));
`ifdef SEG_LEADING_ZERO_BLANK_EN
  // blank when this digit and every higher one are zero; digit 0 always shows
  always_comb begin
    lz = ptr != '0;
    for (int k = 0; k < N_DIGITS; k++)
      if (k >= int'(ptr) && digit[k] != 4'd0) lz = 1'b0;
  end
`else
  assign lz = 1'b0;
`endif
  always_comb begin
    an_n = '1;
    if (state == SHOW) an_n[ptr] = ~digit_en[ptr];
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= SHOW;
      presc      <= '0;
      ptr        <= '0;
      for (int i = 0; i < N_DIGITS; i++) digit[i] <= '0;
      oAn        <= '1;
      oSeg       <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      ptr        <= ptr_n;
      if (wr.wr_en && {1'b0, wr.wr_addr} < N_L) digit[wr.wr_addr[PW-1:0]] <= wr.wr_data;
      oAn        <= an_n;
      oSeg       <= (state == SHOW && !lz) ? dec : SEG_BLANK;
      frame_done <= wrap;
    end
  end
endmodule
